// File: rtl/ts_os_receiver.sv
// Receive-side TS1/TS2 ordered-set parser for one 8b/10b lane.
// It validates 16-symbol sets, latches the training fields and counts consecutive identical sets.
module ts_os_receiver #(
    parameter int unsigned CONSEC_TARGET = 8,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sym_valid_i,
    input  logic [7:0]       sym_data_i,
    input  logic             sym_is_k_i,
    input  logic             sym_err_i,
    input  logic             clear_cnt_i,
    output logic             ts1_rcvd_o,
    output logic             ts2_rcvd_o,
    output logic [7:0]       link_num_o,
    output logic [7:0]       lane_num_o,
    output logic             link_pad_o,
    output logic             lane_pad_o,
    output logic [7:0]       n_fts_o,
    output logic [7:0]       rate_id_o,
    output logic [7:0]       train_ctrl_o,
    output logic [CNT_W-1:0] consec_cnt_o,
    output logic             consec_is_ts2_o,
    output logic             ts1_target_o,
    output logic             ts2_target_o
);

    localparam int unsigned SYM_W = 8;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned KEY_W = 1 + 2 * (SYM_W + 1) + 3 * SYM_W;

    localparam logic [SYM_W-1:0] SYM_COM = 8'hBC;
    localparam logic [SYM_W-1:0] SYM_PAD = 8'hF7;
    localparam logic [SYM_W-1:0] SYM_TS1 = 8'h4A;
    localparam logic [SYM_W-1:0] SYM_TS2 = 8'h45;

    localparam logic [IDX_W-1:0] IDX_FIRST      = 4'd1;
    localparam logic [IDX_W-1:0] IDX_PAD_LAST   = 4'd2;
    localparam logic [IDX_W-1:0] IDX_FIELD_LAST = 4'd5;
    localparam logic [IDX_W-1:0] IDX_IDENT      = 4'd6;
    localparam logic [IDX_W-1:0] IDX_LAST       = 4'd15;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_FIELDS = 2'd1,
        ST_IDENT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [SYM_W-1:0]   sh_link, sh_lane, sh_nfts, sh_rate, sh_ctrl, ident_q;
    logic               sh_link_pad, sh_lane_pad;
    logic               sh_ts2;
    logic [KEY_W-1:0]   sh_key;

    logic [KEY_W-1:0]   ref_key_q, ref_key_d;
    logic               ref_valid_q, ref_valid_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               is_ts2_d;

    logic               is_com, sym_good, in_set, accept, malformed, complete, identical;

    assign sh_ts2 = (ident_q == SYM_TS2);
    assign sh_key = {sh_ts2, sh_link_pad, sh_link, sh_lane_pad, sh_lane, sh_nfts, sh_rate, sh_ctrl};

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_HUNT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: a valid COM always (re)starts a set; any other bad symbol drops to HUNT
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (sym_valid_i) begin
            case (state_q)
                ST_HUNT: begin
                    if (is_com) begin
                        state_d = ST_FIELDS;
                        idx_d   = IDX_FIRST;
                    end
                end
                ST_FIELDS, ST_IDENT: begin
                    if (malformed) begin
                        state_d = is_com ? ST_FIELDS : ST_HUNT;
                        idx_d   = is_com ? IDX_FIRST : '0;
                    end else if (idx_q == IDX_FIELD_LAST) begin
                        state_d = ST_IDENT;
                        idx_d   = IDX_IDENT;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = ST_HUNT;
                        idx_d   = '0;
                    end else begin
                        idx_d = IDX_W'(idx_q + 4'd1);
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Symbol classification and consecutive-set bookkeeping
    always_comb begin
        is_com   = sym_is_k_i && (sym_data_i == SYM_COM) && !sym_err_i;
        sym_good = 1'b0;
        case (state_q)
            ST_FIELDS: begin
                if (idx_q <= IDX_PAD_LAST) sym_good = !sym_is_k_i || (sym_data_i == SYM_PAD);
                else                       sym_good = !sym_is_k_i;
            end
            ST_IDENT: begin
                if (idx_q == IDX_IDENT)
                    sym_good = !sym_is_k_i && ((sym_data_i == SYM_TS1) || (sym_data_i == SYM_TS2));
                else
                    sym_good = !sym_is_k_i && (sym_data_i == ident_q);
            end
            default: sym_good = 1'b0;
        endcase
        sym_good  = sym_good && !sym_err_i;
        in_set    = sym_valid_i && (state_q != ST_HUNT);
        accept    = in_set && sym_good;
        malformed = in_set && !sym_good;
        complete  = accept && (state_q == ST_IDENT) && (idx_q == IDX_LAST);
        identical = ref_valid_q && (ref_key_q == sh_key);

        cnt_d       = consec_cnt_o;
        ref_key_d   = ref_key_q;
        ref_valid_d = ref_valid_q;
        is_ts2_d    = consec_is_ts2_o;
        if (complete) begin
            if (identical) begin
                cnt_d = (consec_cnt_o == CNT_MAX) ? consec_cnt_o : CNT_W'(consec_cnt_o + 1'b1);
            end else begin
                cnt_d       = CNT_W'(1);
                ref_key_d   = sh_key;
                ref_valid_d = 1'b1;
                is_ts2_d    = sh_ts2;
            end
        end
        if (malformed) cnt_d = '0;
        // A state-entry clear overrides a coincident completion
        if (clear_cnt_i) begin
            cnt_d       = '0;
            ref_valid_d = 1'b0;
            is_ts2_d    = consec_is_ts2_o;
        end
    end

    // Shadow capture, output registers and reference
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_link         <= '0;
            sh_lane         <= '0;
            sh_nfts         <= '0;
            sh_rate         <= '0;
            sh_ctrl         <= '0;
            sh_link_pad     <= 1'b0;
            sh_lane_pad     <= 1'b0;
            ident_q         <= '0;
            ts1_rcvd_o      <= 1'b0;
            ts2_rcvd_o      <= 1'b0;
            link_num_o      <= '0;
            lane_num_o      <= '0;
            link_pad_o      <= 1'b0;
            lane_pad_o      <= 1'b0;
            n_fts_o         <= '0;
            rate_id_o       <= '0;
            train_ctrl_o    <= '0;
            consec_cnt_o    <= '0;
            consec_is_ts2_o <= 1'b0;
            ref_key_q       <= '0;
            ref_valid_q     <= 1'b0;
        end else begin
            ts1_rcvd_o <= complete && !sh_ts2;
            ts2_rcvd_o <= complete && sh_ts2;
            if (accept && (state_q == ST_FIELDS)) begin
                case (idx_q)
                    4'd1: begin sh_link <= sym_data_i; sh_link_pad <= sym_is_k_i; end
                    4'd2: begin sh_lane <= sym_data_i; sh_lane_pad <= sym_is_k_i; end
                    4'd3: sh_nfts <= sym_data_i;
                    4'd4: sh_rate <= sym_data_i;
                    4'd5: sh_ctrl <= sym_data_i;
                    default: ;
                endcase
            end
            if (accept && (state_q == ST_IDENT) && (idx_q == IDX_IDENT)) ident_q <= sym_data_i;
            if (complete) begin
                link_num_o   <= sh_link;
                lane_num_o   <= sh_lane;
                link_pad_o   <= sh_link_pad;
                lane_pad_o   <= sh_lane_pad;
                n_fts_o      <= sh_nfts;
                rate_id_o    <= sh_rate;
                train_ctrl_o <= sh_ctrl;
            end
            consec_cnt_o    <= cnt_d;
            consec_is_ts2_o <= is_ts2_d;
            ref_key_q       <= ref_key_d;
            ref_valid_q     <= ref_valid_d;
        end
    end

    assign ts1_target_o = !consec_is_ts2_o && (32'(consec_cnt_o) >= CONSEC_TARGET);
    assign ts2_target_o =  consec_is_ts2_o && (32'(consec_cnt_o) >= CONSEC_TARGET);

endmodule

// File: tb/tb_ts_os_receiver.sv
// Bench for ts_os_receiver: a set-level model (prefix queue of received symbols)
// checked every cycle, plus literal expectations on counts and fields per scenario.
module tb_ts_os_receiver;

    localparam int unsigned CONSEC_TARGET = 8;
    localparam int unsigned CNT_W         = 4;
    localparam int          CNT_SAT       = 15;

    localparam logic [8:0] K_COM = 9'h1BC;
    localparam logic [8:0] K_PAD = 9'h1F7;
    localparam logic [8:0] K_SKP = 9'h11C;
    localparam logic [8:0] D_TS1 = 9'h04A;
    localparam logic [8:0] D_TS2 = 9'h045;

    logic clk = 1'b0;
    logic rst, valid, k, err, clr;
    logic [7:0] data;
    logic ts1_rcvd_o, ts2_rcvd_o, link_pad_o, lane_pad_o, consec_is_ts2_o, ts1_target_o, ts2_target_o;
    logic [7:0] link_num_o, lane_num_o, n_fts_o, rate_id_o, train_ctrl_o;
    logic [CNT_W-1:0] consec_cnt_o;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;
    bit gaps    = 1'b0;

    always #5 clk = ~clk;

    ts_os_receiver #(.CONSEC_TARGET(CONSEC_TARGET), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .sym_valid_i(valid), .sym_data_i(data), .sym_is_k_i(k),
        .sym_err_i(err), .clear_cnt_i(clr),
        .ts1_rcvd_o(ts1_rcvd_o), .ts2_rcvd_o(ts2_rcvd_o),
        .link_num_o(link_num_o), .lane_num_o(lane_num_o),
        .link_pad_o(link_pad_o), .lane_pad_o(lane_pad_o),
        .n_fts_o(n_fts_o), .rate_id_o(rate_id_o), .train_ctrl_o(train_ctrl_o),
        .consec_cnt_o(consec_cnt_o), .consec_is_ts2_o(consec_is_ts2_o),
        .ts1_target_o(ts1_target_o), .ts2_target_o(ts2_target_o)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [8:0]  cur[$];
    logic [53:0] ref_key;
    bit          ref_ok;
    int          m_cnt;
    bit          m_is_ts2, m_ts1, m_ts2, m_link_pad, m_lane_pad;
    logic [7:0]  m_link, m_lane, m_nfts, m_rate, m_ctrl;

    // Is s an acceptable next symbol for the partial set held in cur?
    function automatic bit fits(input logic [8:0] s);
        int pos = cur.size();
        if (pos <= 2) return !s[8] || (s == K_PAD);
        if (pos <= 5) return !s[8];
        if (pos == 6) return (s == D_TS1) || (s == D_TS2);
        return s == cur[6];
    endfunction

    function automatic logic [7:0] low8(input logic [8:0] s);
        return s[7:0];
    endfunction

    always @(posedge clk) begin : model
        logic [8:0]  s;
        logic [53:0] key;
        m_ts1 = 1'b0;
        m_ts2 = 1'b0;
        if (rst) begin
            cur.delete();
            ref_ok = 1'b0; m_cnt = 0; m_is_ts2 = 1'b0;
            m_link = '0; m_lane = '0; m_nfts = '0; m_rate = '0; m_ctrl = '0;
            m_link_pad = 1'b0; m_lane_pad = 1'b0;
        end else begin
            if (valid) begin
                s = {k, data};
                if (cur.size() == 0) begin
                    if (!err && s == K_COM) cur.push_back(s);
                end else if (!err && fits(s)) begin
                    cur.push_back(s);
                    if (cur.size() == 16) begin
                        m_link = low8(cur[1]); m_link_pad = (cur[1] == K_PAD);
                        m_lane = low8(cur[2]); m_lane_pad = (cur[2] == K_PAD);
                        m_nfts = low8(cur[3]); m_rate = low8(cur[4]); m_ctrl = low8(cur[5]);
                        m_ts2 = (cur[6] == D_TS2);
                        m_ts1 = !m_ts2;
                        key = {cur[6], cur[1], cur[2], cur[3], cur[4], cur[5]};
                        if (!clr) begin
                            if (ref_ok && key == ref_key) begin
                                if (m_cnt < CNT_SAT) m_cnt++;
                            end else begin
                                m_cnt = 1; ref_key = key; ref_ok = 1'b1; m_is_ts2 = m_ts2;
                            end
                        end
                        cur.delete();
                    end
                end else begin
                    m_cnt = 0;
                    cur.delete();
                    if (!err && s == K_COM) cur.push_back(s);
                end
            end
            if (clr) begin
                m_cnt = 0;
                ref_ok = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("ts1_rcvd", 32'(ts1_rcvd_o), 32'(m_ts1));
            cmp("ts2_rcvd", 32'(ts2_rcvd_o), 32'(m_ts2));
            cmp("link_num", 32'(link_num_o), 32'(m_link));
            cmp("lane_num", 32'(lane_num_o), 32'(m_lane));
            cmp("link_pad", 32'(link_pad_o), 32'(m_link_pad));
            cmp("lane_pad", 32'(lane_pad_o), 32'(m_lane_pad));
            cmp("n_fts", 32'(n_fts_o), 32'(m_nfts));
            cmp("rate_id", 32'(rate_id_o), 32'(m_rate));
            cmp("train_ctrl", 32'(train_ctrl_o), 32'(m_ctrl));
            cmp("consec_cnt", 32'(consec_cnt_o), 32'(m_cnt));
            cmp("consec_is_ts2", 32'(consec_is_ts2_o), 32'(m_is_ts2));
            cmp("ts1_target", 32'(ts1_target_o), 32'(!m_is_ts2 && m_cnt >= CONSEC_TARGET));
            cmp("ts2_target", 32'(ts2_target_o), 32'(m_is_ts2 && m_cnt >= CONSEC_TARGET));
        end
    end

    // Record the counter value seen with every completion pulse
    int pulse_q[$];
    int exp_q[$];
    always @(negedge clk) begin
        if (ts1_rcvd_o === 1'b1 || ts2_rcvd_o === 1'b1) pulse_q.push_back(int'(consec_cnt_o));
    end

    task automatic check_pulses(input string name);
        cmp($sformatf("%s_pulses", name), 32'(pulse_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < pulse_q.size(); i++)
            cmp($sformatf("%s_cnt%0d", name, i), 32'(pulse_q[i]), 32'(exp_q[i]));
        pulse_q.delete();
        exp_q.delete();
    endtask

    task automatic expect_seq(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_q.push_back(i);
    endtask

    // ---------------- stimulus ----------------
    logic [8:0] set_buf[16];

    task automatic drive(input bit v, input logic [8:0] s, input bit e, input bit c);
        @(negedge clk);
        valid = v; k = s[8]; data = s[7:0]; err = e; clr = c;
    endtask

    task automatic sym(input logic [8:0] s, input bit e, input bit c);
        if (gaps)
            while ($urandom_range(0, 2) == 0)
                drive(1'b0, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), 1'b0);
        drive(1'b1, s, e, c);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic build(input bit ts2, input logic [8:0] l1, input logic [8:0] l2,
                         input logic [7:0] nfts, input logic [7:0] rate, input logic [7:0] ctrl);
        set_buf[0] = K_COM;
        set_buf[1] = l1;
        set_buf[2] = l2;
        set_buf[3] = {1'b0, nfts};
        set_buf[4] = {1'b0, rate};
        set_buf[5] = {1'b0, ctrl};
        for (int i = 6; i < 16; i++) set_buf[i] = ts2 ? D_TS2 : D_TS1;
    endtask

    task automatic send(input int n_sym, input int err_pos, input int clr_pos);
        for (int i = 0; i < n_sym; i++) sym(set_buf[i], i == err_pos, i == clr_pos);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; k = 1'b0; data = 8'h00; err = 1'b0; clr = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        cmp("reset_cnt", 32'(consec_cnt_o), 32'd0);
        cmp("reset_link", 32'(link_num_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 8 identical TS1 sets with PAD link/lane
        build(1'b0, K_PAD, K_PAD, 8'h20, 8'h02, 8'h00);
        repeat (8) send(16, -1, -1);
        idle(2);
        expect_seq(1, 8);
        check_pulses("ts1x8");
        cmp("ts1x8_cnt", 32'(consec_cnt_o), 32'd8);
        cmp("ts1x8_model_cnt", 32'(m_cnt), 32'd8);
        cmp("ts1x8_target", 32'(ts1_target_o), 32'd1);
        cmp("ts1x8_link_pad", 32'(link_pad_o), 32'd1);
        cmp("ts1x8_lane_pad", 32'(lane_pad_o), 32'd1);
        cmp("ts1x8_nfts", 32'(n_fts_o), 32'h20);

        // 7 TS2 then one with a different lane number
        build(1'b1, 9'h005, 9'h000, 8'h20, 8'h02, 8'h00);
        repeat (7) send(16, -1, -1);
        build(1'b1, 9'h005, 9'h001, 8'h20, 8'h02, 8'h00);
        send(16, -1, -1);
        idle(2);
        expect_seq(1, 7);
        exp_q.push_back(1);
        check_pulses("ts2");
        cmp("ts2_lane", 32'(lane_num_o), 32'h01);
        cmp("ts2_target", 32'(ts2_target_o), 32'd0);
        cmp("ts2_type", 32'(consec_is_ts2_o), 32'd1);

        // Wrong identifier at symbol 9, then COM at symbol 12 realigning onto a full TS1
        build(1'b0, K_PAD, K_PAD, 8'h20, 8'h02, 8'h00);
        set_buf[9] = D_TS2;
        send(16, -1, -1);
        idle(2);
        cmp("badid_cnt", 32'(consec_cnt_o), 32'd0);
        cmp("badid_pulses", 32'(pulse_q.size()), 32'd0);
        build(1'b0, K_PAD, K_PAD, 8'h20, 8'h02, 8'h00);
        send(12, -1, -1);
        send(16, -1, -1);
        idle(2);
        exp_q.push_back(1);
        check_pulses("realign");

        // Errored symbol 3 drops the set; SKPs in HUNT do not disturb counting
        send(16, -1, -1);
        send(16, -1, -1);
        send(16, 3, -1);
        idle(2);
        cmp("err_cnt", 32'(consec_cnt_o), 32'd0);
        repeat (3) begin
            sym(K_SKP, 1'b0, 1'b0);
            sym(K_SKP, 1'b1, 1'b0);
            sym(K_SKP, 1'b0, 1'b0);
            send(16, -1, -1);
        end
        idle(2);
        expect_seq(2, 3);
        expect_seq(1, 3);
        check_pulses("skp");
        cmp("skp_cnt", 32'(consec_cnt_o), 32'd3);

        // Clear while idle, then clear coincident with the 5th completion
        drive(1'b0, 9'h000, 1'b0, 1'b1);
        repeat (4) send(16, -1, -1);
        send(16, -1, 15);
        send(16, -1, -1);
        idle(2);
        expect_seq(1, 4);
        exp_q.push_back(0);
        exp_q.push_back(1);
        check_pulses("clear");

        // Reset at symbol 8 of a set, then 16 sets with random valid gaps
        send(8, -1, -1);
        drive(1'b1, set_buf[8], 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 9'h000, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 9; i < 16; i++) sym(set_buf[i], 1'b0, 1'b0);
        idle(1);
        cmp("rst_cnt", 32'(consec_cnt_o), 32'd0);
        cmp("rst_link_pad", 32'(link_pad_o), 32'd0);
        cmp("rst_nfts", 32'(n_fts_o), 32'd0);
        cmp("rst_target", 32'(ts1_target_o), 32'd0);
        cmp("rst_pulses", 32'(pulse_q.size()), 32'd0);
        gaps = 1'b1;
        repeat (16) send(16, -1, -1);
        gaps = 1'b0;
        idle(2);
        expect_seq(1, 15);
        exp_q.push_back(15);
        check_pulses("gaps");
        cmp("gaps_cnt_sat", 32'(consec_cnt_o), 32'd15);
        cmp("gaps_target", 32'(ts1_target_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ts_os_receiver.md
# ts_os_receiver

Single-lane receive-side parser for PCIe 8b/10b training ordered sets (TS1/TS2, Gen1/Gen2 format). It sits between the lane's 8b/10b decoder and the LTSSM controller. It consumes decoded symbols, validates 16-symbol TS1/TS2 sets, extracts the link, lane and training fields, and tracks consecutive identical sets so the LTSSM can evaluate Polling and Configuration exit conditions.

## Interface
- `CONSEC_TARGET`, default 8: number of consecutive identical sets that asserts `ts1_target_o` or `ts2_target_o`.
- `CNT_W`, default 4: width of the consecutive counter; must satisfy 2^CNT_W > CONSEC_TARGET.

- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `sym_valid_i`  in  1  decoded symbol present this cycle; the parser advances only on valid cycles.
- `sym_data_i`  in  8  decoded symbol byte.
- `sym_is_k_i`  in  1  symbol is a K (control) character.
- `sym_err_i`  in  1  decode or disparity error on this symbol.
- `clear_cnt_i`  in  1  LTSSM state-entry clear of the consecutive tracking.
- `ts1_rcvd_o`  out  1  one-cycle pulse: a valid TS1 completed.
- `ts2_rcvd_o`  out  1  one-cycle pulse: a valid TS2 completed.
- `link_num_o`  out  8  symbol 1 of the last valid set.
- `lane_num_o`  out  8  symbol 2 of the last valid set.
- `link_pad_o`  out  1  symbol 1 was PAD.
- `lane_pad_o`  out  1  symbol 2 was PAD.
- `n_fts_o`, `rate_id_o`, `train_ctrl_o`  out  8 each  symbols 3, 4 and 5 of the last valid set.
- `consec_cnt_o`  out  CNT_W  count of consecutive identical sets.
- `consec_is_ts2_o`  out  1  type of the set being counted.
- `ts1_target_o`, `ts2_target_o`  out  1 each  level: the count has reached CONSEC_TARGET for that type.

## Operation
- Symbol constants:
  - COM = K28.5 (0xBC, K)
  - PAD = K23.7 (0xF7, K)
  - SKP = K28.0 (0x1C, K)
  - TS1 identifier = D10.2 (0x4A, D)
  - TS2 identifier = D5.2 (0x45, D)
- States: HUNT, FIELDS, IDENT. A 4-bit symbol index `idx` tracks position within the set.
- HUNT:
  - A valid COM moves to FIELDS with idx=1.
  - All other symbols are ignored, including SKP and errored symbols.
- FIELDS (idx 1..5):
  - Symbols 1 and 2: accept a D symbol, or PAD as K. The PAD flag is captured for each.
  - Symbols 3..5: must be D symbols.
  - Each accepted symbol is captured into a shadow register. At idx=5 the state moves to IDENT.
- IDENT (idx 6..15):
  - Symbol 6 must be D 0x4A or D 0x45; it fixes the set type.
  - Symbols 7..15 must equal symbol 6.
  - Symbol 15 completes the set.
- Malformed set: an errored symbol, a wrong K/D class, a wrong value, or a COM at idx≥1.
  - The set is discarded and the counter is cleared to 0.
  - If the offending symbol is a valid COM, the parser realigns directly to FIELDS with idx=1. Otherwise it returns to HUNT.
- On completion of a valid set:
  - Shadow fields copy to the output registers.
  - The matching pulse asserts.
  - The set is "identical" if its type and symbols 1..5 (including PAD flags) equal the reference.
  - Identical: the counter increments, saturating at 2^CNT_W−1.
  - Not identical: the counter becomes 1 and the reference is reloaded with this set.
- `ts1_target_o` = !consec_is_ts2_o && consec_cnt_o ≥ CONSEC_TARGET. `ts2_target_o` is the same with the type inverted.
- `clear_cnt_i`:
  - Sets the counter to 0 and invalidates the reference, so the next valid set counts as 1.
  - It does not affect parser state, pulses or field outputs.

## Timing
- Reset values:
  - State HUNT, idx=0.
  - All outputs 0: pulses, fields, pad flags, `consec_cnt_o`, `consec_is_ts2_o`, targets.
  - Reference marked invalid.
- Reset mid-set discards the partial set. There is no carry-over.
- Latency: symbol 15 is accepted at edge N. At edge N+1 the pulse, fields and counter are visible. The pulse is high for exactly one cycle.
- Gaps: `sym_valid_i` low holds all parser state indefinitely. Completion still requires 16 valid symbols.
- Back-to-back sets:
  - A COM on the cycle after symbol 15 is accepted as the start of the next set.
  - Consecutive pulses are therefore 16 valid cycles apart at minimum.
- `clear_cnt_i` on the same edge as a set completion: the clear wins, so the counter becomes 0 and the reference is invalid. The pulse and field update still occur.
- Targets are combinational from the registered counter and type, so they are valid in the same cycle as `consec_cnt_o`.

## Test plan
- Reset, then 8 back-to-back TS1 sets with link=PAD, lane=PAD, N_FTS=0x20, rate=0x02, ctrl=0x00 → 8 `ts1_rcvd_o` pulses. `consec_cnt_o` reads 1..8, `ts1_target_o` rises after the 8th, and `link_pad_o`=`lane_pad_o`=1.
- 7 identical TS2 sets, then a TS2 with lane=0x01 → count 7, then 1. `lane_num_o`=0x01, `ts2_target_o` stays 0.
- TS1 with symbol 9 = 0x45 → no pulse, counter 0. A COM at symbol 12 of the next set, followed by a full valid TS1 → exactly one pulse, count 1.
- `sym_err_i` on symbol 3, and SKP sets between valid TS1s → the errored set is dropped and the count clears. SKPs in HUNT do not break counting: 3 TS1s with SKPs between them reach count 3.
- `clear_cnt_i` coincident with completion of the 5th identical TS1 → `ts1_rcvd_o` pulses, count becomes 0, and the next identical TS1 gives count 1.
- `sym_valid_i` toggled randomly low during 16 sets; also `rst_i` asserted at symbol 8 → set counts match the no-gap run exactly. After reset all outputs are 0, and the first full set after reset gives count 1.
